// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   - DEFAULT_WIDTH : operand width used when the parent does not override it
//   - ST_*          : raw 2-bit state codes; the fourth code (2'd3) is unused
//   - state_e       : enumerated view of the state register
//   - decode_state  : maps a raw state code onto state_e, folding 2'd3 into IDLE
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // The unused code is treated as IDLE so a corrupted state register
    // recovers on its own instead of locking the controller up.
    function automatic state_e decode_state(input logic [1:0] raw);
        case (raw)
            ST_RUN:  return S_RUN;
            ST_DONE: return S_DONE;
            default: return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder_cell.sv
// One-bit adder cells used by the serial adder.
//   half_adder      : a, b -> s (sum), c (carry)
//   full_adder_cell : a, b, cin -> s (sum), cout (carry)
// Both are purely combinational.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    // The two half-adder carries can never both be 1, so OR is the majority.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first using
// a single full-adder cell over WIDTH cycles.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request pulse, only honoured in IDLE
//   a, b      in   operands, captured when start is accepted
//   busy      out  high while the addition is running
//   done      out  one-cycle pulse when sum/carry_out are updated
//   sum       out  registered result, held until the next completion
//   carry_out out  registered final carry, held until the next completion
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic fa_s;
    logic fa_co;

    full_adder_cell u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (decode_state(state_q))
            S_RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) result bit has arrived at position 0.
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            S_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                // Also normalises the unused code back to IDLE.
                state_d = ST_IDLE;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule
